// File: rtl/atm_keypad_entry.sv
// rtl/atm_keypad_entry.sv - keypad credential entry, submit strobe and auth lockout tracking
module atm_keypad_entry #(
    parameter int ACC_DIGITS     = 4,
    parameter int PIN_DIGITS     = 4,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int MAX_ATTEMPTS   = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        auth_ok,
    input  logic        auth_fail,
    input  logic        session_end,
    output logic [11:0] accountNum,
    output logic [13:0] pin,
    output logic        cred_valid,
    output logic        entry_error,
    output logic        timeout,
    output logic        card_locked,
    output logic [2:0]  digit_count,
    output logic        in_pin_field
);

    localparam logic [2:0] IDLE        = 3'd0;
    localparam logic [2:0] ACC_ENTRY   = 3'd1;
    localparam logic [2:0] PIN_ENTRY   = 3'd2;
    localparam logic [2:0] SUBMIT      = 3'd3;
    localparam logic [2:0] WAIT_RESULT = 3'd4;
    localparam logic [2:0] SESSION     = 3'd5;
    localparam logic [2:0] LOCKED      = 3'd6;

    localparam logic [3:0] KEY_BS     = 4'hA;
    localparam logic [3:0] KEY_ENTER  = 4'hB;
    localparam logic [3:0] KEY_CANCEL = 4'hC;

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int AW = $clog2(MAX_ATTEMPTS + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [2:0]    state, state_n;
    logic [13:0]   acc, acc_n, pacc, pacc_n;
    logic [TW-1:0] timer, timer_n;
    logic [AW-1:0] attempts, attempts_n;
    logic [2:0]    cnt_n;
    logic [11:0]   acct_n;
    logic [13:0]   pin_n;
    logic          cred_n, err_n, tmo_n;

    logic          pin_field, is_digit;
    logic [2:0]    limit;
    logic [13:0]   field, field_dig, field_bs;

    always_comb begin
        state_n    = state;
        acc_n      = acc;
        pacc_n     = pacc;
        cnt_n      = digit_count;
        timer_n    = timer;
        attempts_n = attempts;
        acct_n     = accountNum;
        pin_n      = pin;
        cred_n     = 1'b0;
        err_n      = 1'b0;
        tmo_n      = 1'b0;

        pin_field  = (state == PIN_ENTRY);
        is_digit   = (key_code <= 4'd9);
        limit      = pin_field ? 3'(PIN_DIGITS) : 3'(ACC_DIGITS);
        field      = pin_field ? pacc : acc;
        field_dig  = field * 14'd10 + {10'd0, key_code};
        field_bs   = field / 14'd10;

        case (state)
            IDLE: begin
                if (key_valid && is_digit) begin
                    acc_n   = {10'd0, key_code};
                    cnt_n   = 3'd1;
                    timer_n = '0;
                    state_n = ACC_ENTRY;
                end
            end
            ACC_ENTRY, PIN_ENTRY: begin
                timer_n = timer + TW'(1);
                // A key on the expiry cycle counts as activity and suppresses the timeout.
                if (key_valid) begin
                    timer_n = '0;
                    if (is_digit) begin
                        if (digit_count < limit) begin
                            if (pin_field) pacc_n = field_dig;
                            else           acc_n  = field_dig;
                            cnt_n = digit_count + 3'd1;
                        end
                    end else if (key_code == KEY_BS) begin
                        if (digit_count != 3'd0) begin
                            if (pin_field) pacc_n = field_bs;
                            else           acc_n  = field_bs;
                            cnt_n = digit_count - 3'd1;
                        end
                    end else if (key_code == KEY_ENTER) begin
                        if (digit_count != limit) begin
                            err_n = 1'b1;
                        end else if (!pin_field) begin
                            if (acc > 14'd4095) begin
                                err_n = 1'b1;
                                acc_n = '0;
                                cnt_n = 3'd0;
                            end else begin
                                pacc_n  = '0;
                                cnt_n   = 3'd0;
                                state_n = PIN_ENTRY;
                            end
                        end else begin
                            state_n = SUBMIT;
                        end
                    end else if (key_code == KEY_CANCEL) begin
                        acc_n   = '0;
                        pacc_n  = '0;
                        cnt_n   = 3'd0;
                        state_n = IDLE;
                    end
                end else if (timer == TIMER_LAST) begin
                    tmo_n   = 1'b1;
                    acc_n   = '0;
                    pacc_n  = '0;
                    cnt_n   = 3'd0;
                    timer_n = '0;
                    state_n = IDLE;
                end
            end
            SUBMIT: begin
                acct_n  = acc[11:0];
                pin_n   = pacc;
                cred_n  = 1'b1;
                state_n = WAIT_RESULT;
            end
            WAIT_RESULT: begin
                if (auth_ok) begin
                    attempts_n = '0;
                    state_n    = SESSION;
                end else if (auth_fail) begin
                    attempts_n = attempts + AW'(1);
                    cnt_n      = 3'd0;
                    if (attempts_n == AW'(MAX_ATTEMPTS)) begin
                        state_n = LOCKED;
                    end else begin
                        pacc_n  = '0;
                        timer_n = '0;
                        state_n = PIN_ENTRY;
                    end
                end
            end
            SESSION: begin
                if (session_end) begin
                    acct_n  = '0;
                    pin_n   = '0;
                    acc_n   = '0;
                    pacc_n  = '0;
                    cnt_n   = 3'd0;
                    state_n = IDLE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            acc          <= '0;
            pacc         <= '0;
            timer        <= '0;
            attempts     <= '0;
            accountNum   <= '0;
            pin          <= '0;
            cred_valid   <= 1'b0;
            entry_error  <= 1'b0;
            timeout      <= 1'b0;
            card_locked  <= 1'b0;
            digit_count  <= 3'd0;
            in_pin_field <= 1'b0;
        end else begin
            state        <= state_n;
            acc          <= acc_n;
            pacc         <= pacc_n;
            timer        <= timer_n;
            attempts     <= attempts_n;
            accountNum   <= acct_n;
            pin          <= pin_n;
            cred_valid   <= cred_n;
            entry_error  <= err_n;
            timeout      <= tmo_n;
            card_locked  <= (state_n == LOCKED);
            digit_count  <= cnt_n;
            in_pin_field <= (state_n == PIN_ENTRY);
        end
    end

endmodule

// File: tb/tb_atm_keypad_entry.sv
// tb/tb_atm_keypad_entry.sv - directed vector bench for atm_keypad_entry
module tb_atm_keypad_entry;

    localparam int T = 1000;

    logic        clk = 1'b0;
    logic        reset;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        auth_ok, auth_fail, session_end;
    logic [11:0] accountNum;
    logic [13:0] pin;
    logic        cred_valid, entry_error, timeout, card_locked, in_pin_field;
    logic [2:0]  digit_count;

    atm_keypad_entry #(
        .ACC_DIGITS(4), .PIN_DIGITS(4), .TIMEOUT_CYCLES(T), .MAX_ATTEMPTS(3)
    ) dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .auth_ok(auth_ok), .auth_fail(auth_fail), .session_end(session_end),
        .accountNum(accountNum), .pin(pin), .cred_valid(cred_valid),
        .entry_error(entry_error), .timeout(timeout), .card_locked(card_locked),
        .digit_count(digit_count), .in_pin_field(in_pin_field)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        kv;
        logic [3:0]  key;
        logic [2:0]  aux;   // {auth_ok, auth_fail, session_end}
        logic [2:0]  cnt;
        logic        pf, err, cred, lk;
        logic [11:0] acct;
        logic [13:0] pin;
    } vec_t;

    vec_t vecs[$];
    int   applied    = 0;
    int   miscompares = 0;
    logic seen;

    task automatic add(input logic kv, input logic [3:0] key, input logic [2:0] aux,
                       input logic [2:0] cnt, input logic pf, input logic err,
                       input logic cred, input logic lk, input logic [11:0] acct,
                       input logic [13:0] p);
        vec_t v;
        v.kv = kv; v.key = key; v.aux = aux; v.cnt = cnt; v.pf = pf; v.err = err;
        v.cred = cred; v.lk = lk; v.acct = acct; v.pin = p;
        vecs.push_back(v);
    endtask

    task automatic cyc(input logic kv, input logic [3:0] key, input logic [2:0] aux);
        key_valid = kv;
        key_code  = key;
        {auth_ok, auth_fail, session_end} = aux;
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        applied++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    initial begin
        logic [33:0] got, exp;

        reset = 1'b1;
        key_valid = 1'b0; key_code = 4'h0;
        auth_ok = 1'b0; auth_fail = 1'b0; session_end = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_cnt", 32'(digit_count), 0);
        chk("reset_outs", {cred_valid, entry_error, timeout, card_locked, in_pin_field}, 0);
        chk("reset_acct", 32'(accountNum), 0);
        chk("reset_pin", 32'(pin), 0);
        reset = 1'b0;

        // account 2179 -> backspace -> 2178, short PIN enter, backspaces, PIN 0100
        add(1,4'd2,0, 1,0,0,0,0, 0,0);
        add(1,4'd1,0, 2,0,0,0,0, 0,0);
        add(1,4'd7,0, 3,0,0,0,0, 0,0);
        add(1,4'd9,0, 4,0,0,0,0, 0,0);
        add(1,4'hA,0, 3,0,0,0,0, 0,0);
        add(1,4'd8,0, 4,0,0,0,0, 0,0);
        add(1,4'hB,0, 0,1,0,0,0, 0,0);
        add(1,4'd1,0, 1,1,0,0,0, 0,0);
        add(1,4'd2,0, 2,1,0,0,0, 0,0);
        add(1,4'hB,0, 2,1,1,0,0, 0,0);
        add(1,4'hA,0, 1,1,0,0,0, 0,0);
        add(1,4'hA,0, 0,1,0,0,0, 0,0);
        add(1,4'hA,0, 0,1,0,0,0, 0,0);
        add(1,4'd0,0, 1,1,0,0,0, 0,0);
        add(1,4'd1,0, 2,1,0,0,0, 0,0);
        add(1,4'd0,0, 3,1,0,0,0, 0,0);
        add(1,4'd0,0, 4,1,0,0,0, 0,0);
        add(1,4'd5,0, 4,1,0,0,0, 0,0);
        add(1,4'hB,0, 4,0,0,0,0, 0,0);
        add(0,4'd0,0, 4,0,0,1,0, 2178,100);
        add(1,4'd5,0, 4,0,0,0,0, 2178,100);
        // reject, re-enter PIN 9999, then simultaneous ok+fail, session, exit
        add(0,4'd0,3'b010, 0,1,0,0,0, 2178,100);
        add(1,4'd9,0, 1,1,0,0,0, 2178,100);
        add(1,4'd9,0, 2,1,0,0,0, 2178,100);
        add(1,4'd9,0, 3,1,0,0,0, 2178,100);
        add(1,4'd9,0, 4,1,0,0,0, 2178,100);
        add(1,4'hB,0, 4,0,0,0,0, 2178,100);
        add(0,4'd0,0, 4,0,0,1,0, 2178,9999);
        add(0,4'd0,3'b110, 4,0,0,0,0, 2178,9999);
        add(1,4'd3,0, 4,0,0,0,0, 2178,9999);
        add(0,4'd0,3'b001, 0,0,0,0,0, 0,0);
        // cancel, enter ignored in idle, short/overflow entries in account field
        add(1,4'd7,0, 1,0,0,0,0, 0,0);
        add(1,4'hC,0, 0,0,0,0,0, 0,0);
        add(1,4'hB,0, 0,0,0,0,0, 0,0);
        add(1,4'd5,0, 1,0,0,0,0, 0,0);
        add(1,4'd0,0, 2,0,0,0,0, 0,0);
        add(1,4'd0,0, 3,0,0,0,0, 0,0);
        add(1,4'd0,0, 4,0,0,0,0, 0,0);
        add(1,4'hB,0, 0,0,1,0,0, 0,0);
        add(1,4'hB,0, 0,0,1,0,0, 0,0);
        add(1,4'd1,0, 1,0,0,0,0, 0,0);
        add(1,4'd2,0, 2,0,0,0,0, 0,0);
        add(1,4'hB,0, 2,0,1,0,0, 0,0);
        add(1,4'hC,0, 0,0,0,0,0, 0,0);
        // 4096 rejected, 4095 accepted
        add(1,4'd4,0, 1,0,0,0,0, 0,0);
        add(1,4'd0,0, 2,0,0,0,0, 0,0);
        add(1,4'd9,0, 3,0,0,0,0, 0,0);
        add(1,4'd6,0, 4,0,0,0,0, 0,0);
        add(1,4'hB,0, 0,0,1,0,0, 0,0);
        add(1,4'd4,0, 1,0,0,0,0, 0,0);
        add(1,4'd0,0, 2,0,0,0,0, 0,0);
        add(1,4'd9,0, 3,0,0,0,0, 0,0);
        add(1,4'd5,0, 4,0,0,0,0, 0,0);
        add(1,4'hB,0, 0,1,0,0,0, 0,0);
        add(1,4'd1,0, 1,1,0,0,0, 0,0);
        add(1,4'd1,0, 2,1,0,0,0, 0,0);
        add(1,4'd1,0, 3,1,0,0,0, 0,0);
        add(1,4'd1,0, 4,1,0,0,0, 0,0);
        add(1,4'hB,0, 4,0,0,0,0, 0,0);
        add(0,4'd0,0, 4,0,0,1,0, 4095,1111);
        // fail 1, cancel keeps the attempt count, fail 2, fail 3 locks
        add(0,4'd0,3'b010, 0,1,0,0,0, 4095,1111);
        add(1,4'hC,0, 0,0,0,0,0, 4095,1111);
        add(1,4'd4,0, 1,0,0,0,0, 4095,1111);
        add(1,4'd0,0, 2,0,0,0,0, 4095,1111);
        add(1,4'd9,0, 3,0,0,0,0, 4095,1111);
        add(1,4'd5,0, 4,0,0,0,0, 4095,1111);
        add(1,4'hB,0, 0,1,0,0,0, 4095,1111);
        add(1,4'd2,0, 1,1,0,0,0, 4095,1111);
        add(1,4'd2,0, 2,1,0,0,0, 4095,1111);
        add(1,4'd2,0, 3,1,0,0,0, 4095,1111);
        add(1,4'd2,0, 4,1,0,0,0, 4095,1111);
        add(1,4'hB,0, 4,0,0,0,0, 4095,1111);
        add(0,4'd0,0, 4,0,0,1,0, 4095,2222);
        add(0,4'd0,3'b010, 0,1,0,0,0, 4095,2222);
        add(1,4'd3,0, 1,1,0,0,0, 4095,2222);
        add(1,4'd3,0, 2,1,0,0,0, 4095,2222);
        add(1,4'd3,0, 3,1,0,0,0, 4095,2222);
        add(1,4'd3,0, 4,1,0,0,0, 4095,2222);
        add(1,4'hB,0, 4,0,0,0,0, 4095,2222);
        add(0,4'd0,0, 4,0,0,1,0, 4095,3333);
        add(0,4'd0,3'b010, 0,0,0,0,1, 4095,3333);
        add(1,4'd1,0, 0,0,0,0,1, 4095,3333);
        add(1,4'hB,0, 0,0,0,0,1, 4095,3333);
        add(0,4'd0,3'b001, 0,0,0,0,1, 4095,3333);

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].kv, vecs[i].key, vecs[i].aux);
            got = {digit_count, in_pin_field, entry_error, cred_valid, card_locked, timeout, accountNum, pin};
            exp = {vecs[i].cnt, vecs[i].pf, vecs[i].err, vecs[i].cred, vecs[i].lk, 1'b0, vecs[i].acct, vecs[i].pin};
            applied++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL vec%0d: got cnt=%0d pf=%b err=%b cred=%b lk=%b tmo=%b acct=%0d pin=%0d, expected cnt=%0d pf=%b err=%b cred=%b lk=%b tmo=0 acct=%0d pin=%0d",
                         i, digit_count, in_pin_field, entry_error, cred_valid, card_locked, timeout, accountNum, pin,
                         vecs[i].cnt, vecs[i].pf, vecs[i].err, vecs[i].cred, vecs[i].lk, vecs[i].acct, vecs[i].pin);
            end
        end

        // reset is the only way out of lockout
        reset = 1'b1;
        cyc(0, 4'd0, 0);
        reset = 1'b0;
        chk("unlock_locked", 32'(card_locked), 0);
        chk("unlock_acct", 32'(accountNum), 0);

        // reset mid-entry
        cyc(1, 4'd1, 0);
        cyc(1, 4'd2, 0);
        chk("mid_cnt", 32'(digit_count), 2);
        reset = 1'b1;
        cyc(1, 4'd3, 0);
        reset = 1'b0;
        chk("mid_reset_cnt", 32'(digit_count), 0);

        // inactivity timeout
        cyc(1, 4'd1, 0);
        cyc(1, 4'd2, 0);
        cyc(0, 4'd0, 0);
        seen = timeout;
        repeat (T - 2) begin
            cyc(0, 4'd0, 0);
            seen = seen | timeout;
        end
        chk("tmo_early", 32'(seen), 0);
        chk("tmo_cnt_before", 32'(digit_count), 2);
        cyc(0, 4'd0, 0);
        chk("tmo_pulse", 32'(timeout), 1);
        chk("tmo_cnt_after", 32'(digit_count), 0);
        cyc(0, 4'd0, 0);
        chk("tmo_one_cycle", 32'(timeout), 0);
        cyc(1, 4'hB, 0);
        chk("tmo_idle_enter", 32'(entry_error), 0);

        // a key on the expiry cycle wins
        cyc(1, 4'd1, 0);
        repeat (T - 1) cyc(0, 4'd0, 0);
        cyc(1, 4'd2, 0);
        chk("keywin_tmo", 32'(timeout), 0);
        chk("keywin_cnt", 32'(digit_count), 2);
        cyc(1, 4'hC, 0);

        // cancel mid-PIN: no credential strobe
        cyc(1, 4'd1, 0); cyc(1, 4'd2, 0); cyc(1, 4'd3, 0); cyc(1, 4'd4, 0);
        cyc(1, 4'hB, 0);
        cyc(1, 4'd5, 0);
        chk("cancel_pf_before", 32'(in_pin_field), 1);
        cyc(1, 4'hC, 0);
        seen = cred_valid;
        cyc(0, 4'd0, 0); seen = seen | cred_valid;
        cyc(0, 4'd0, 0); seen = seen | cred_valid;
        chk("cancel_no_cred", 32'(seen), 0);
        chk("cancel_pf_after", 32'(in_pin_field), 0);

        // reset mid-session clears held credentials
        cyc(1, 4'd1, 0); cyc(1, 4'd2, 0); cyc(1, 4'd3, 0); cyc(1, 4'd4, 0); cyc(1, 4'hB, 0);
        cyc(1, 4'd4, 0); cyc(1, 4'd3, 0); cyc(1, 4'd2, 0); cyc(1, 4'd1, 0); cyc(1, 4'hB, 0);
        chk("sess_cred_early", 32'(cred_valid), 0);
        cyc(0, 4'd0, 0);
        chk("sess_cred", 32'(cred_valid), 1);
        chk("sess_acct", 32'(accountNum), 1234);
        chk("sess_pin", 32'(pin), 4321);
        cyc(0, 4'd0, 3'b100);
        reset = 1'b1;
        cyc(0, 4'd0, 0);
        reset = 1'b0;
        chk("sess_reset_acct", 32'(accountNum), 0);
        chk("sess_reset_pin", 32'(pin), 0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
